// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Supervises a PLL from the reference clock: pulses the PLL
//               reset, qualifies lock stability and sequences sys_rst_n.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             running,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int C_MAX_A   = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int C_MAX_LEN = (STABLE_CYCLES > C_MAX_A) ? STABLE_CYCLES : C_MAX_A;
    localparam int C_TMR_W   = (C_MAX_LEN > 1) ? $clog2(C_MAX_LEN) : 1;

    localparam logic [C_TMR_W-1:0] C_RST_LAST    = C_TMR_W'(RST_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_LOCK_LAST   = C_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [C_TMR_W-1:0] C_STABLE_LAST = C_TMR_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [C_TMR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               sync1_q, lk_s_q;
    logic               pll_rst_q, sys_rst_n_q, running_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == C_LOCK_LAST) begin
                    state_d = ST_PLL_RST;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A single low sample restarts qualification from WAIT_LOCK
                if (!lk_s_q)                    state_d = ST_WAIT_LOCK;
                else if (cnt_q == C_STABLE_LAST) state_d = ST_RUN;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d = ST_PLL_RST;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are registered from the next state so they track state_q exactly
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            sync1_q     <= 1'b0;
            lk_s_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync1_q     <= pll_locked;
            lk_s_q      <= sync1_q;
            pll_rst_q   <= (state_d == ST_PLL_RST);
            sys_rst_n_q <= (state_d == ST_RUN);
            running_q   <= (state_d == ST_RUN);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign running   = running_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Directed, self-checking bench with a cycle-level reference
//               model of the lock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int ST_C  = 8;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_RUN   = 3;

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       running;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C),
        .CNT_W         (8)
    ) u_dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .running    (running),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #10 refclk = ~refclk;

    // Reference model: phase plus a countdown of edges left in that phase
    int m_phase = PH_PULSE;
    int m_left  = RST_C;
    int m_retry = 0;
    int m_loss  = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge refclk) begin
        bit lk;
        if (!rst_n) begin
            m_phase = PH_PULSE;
            m_left  = RST_C;
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            case (m_phase)
                PH_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_WAIT; m_left = TO_C; end
                end
                PH_WAIT: begin
                    if (lk) begin
                        m_phase = PH_QUAL; m_left = ST_C;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_PULSE; m_left = RST_C;
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        end
                    end
                end
                PH_QUAL: begin
                    if (!lk) begin
                        m_phase = PH_WAIT; m_left = TO_C;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_phase = PH_RUN;
                    end
                end
                default: begin
                    if (!lk) begin
                        m_phase = PH_PULSE; m_left = RST_C;
                        m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                    end
                end
            endcase
        end
    end

    always @(negedge refclk) begin
        logic [18:0] act;
        logic [18:0] exp;
        if (m_valid) begin
            exp = {m_phase == PH_PULSE, m_phase == PH_RUN, m_phase == PH_RUN,
                   8'(m_retry), 8'(m_loss)};
            act = {pll_rst, sys_rst_n, running, retry_cnt, loss_cnt};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model t=%0t got {rst,sysn,run,retry,loss}=%b,%b,%b,%0d,%0d want %b,%b,%b,%0d,%0d",
                         $time, act[18], act[17], act[16], act[15:8], act[7:0],
                         exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_running(input int limit, input string name);
        int k = 0;
        while (running !== 1'b1 && k < limit) begin
            step(1);
            k++;
        end
        check(name, 32'(running), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        step(3);

        // Locked throughout: pulse edges 0-3, release after edge 12
        rst_n = 1'b1;
        step(3);
        check("t1 pll_rst held", 32'(pll_rst), 32'd1);
        check("t1 sys_rst_n low in reset", 32'(sys_rst_n), 32'd0);
        step(1);
        check("t1 pll_rst released", 32'(pll_rst), 32'd0);
        step(8);
        check("t1 sys_rst_n before window", 32'(sys_rst_n), 32'd0);
        step(1);
        check("t1 sys_rst_n rises", 32'(sys_rst_n), 32'd1);
        check("t1 running", 32'(running), 32'd1);
        check("t1 retry_cnt", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN: outputs react on the third edge
        pll_locked = 1'b0;
        step(2);
        check("t4 pll_rst before N+3", 32'(pll_rst), 32'd0);
        check("t4 sys_rst_n before N+3", 32'(sys_rst_n), 32'd1);
        step(1);
        check("t4 pll_rst at N+3", 32'(pll_rst), 32'd1);
        check("t4 sys_rst_n at N+3", 32'(sys_rst_n), 32'd0);
        check("t4 loss_cnt", 32'(loss_cnt), 32'd1);
        pll_locked = 1'b1;
        step(12);
        check("t4 relock not yet running", 32'(sys_rst_n), 32'd0);
        step(1);
        check("t4 relock running", 32'(sys_rst_n), 32'd1);

        // Build loss_cnt up to 5 then pulse rst_n
        for (int i = 0; i < 4; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            wait_running(40, "t5 relock");
        end
        check("t5 loss_cnt five", 32'(loss_cnt), 32'd5);
        rst_n = 1'b0;
        step(1);
        check("t5 pll_rst", 32'(pll_rst), 32'd1);
        check("t5 sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("t5 running", 32'(running), 32'd0);
        check("t5 loss_cnt", 32'(loss_cnt), 32'd0);
        check("t5 retry_cnt", 32'(retry_cnt), 32'd0);
        rst_n = 1'b1;

        // One-cycle dropout during STABLE delays release to edge 18
        step(7);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(5);
        check("t3 no release at edge 12", 32'(sys_rst_n), 32'd0);
        step(5);
        check("t3 no release at edge 17", 32'(sys_rst_n), 32'd0);
        step(1);
        check("t3 release at edge 18", 32'(sys_rst_n), 32'd1);
        check("t3 retry_cnt", 32'(retry_cnt), 32'd0);

        // Toggling lock never qualifies
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) pll_locked = ~pll_locked;
            step(1);
            check("t6 sys_rst_n", 32'(sys_rst_n), 32'd0);
            check("t6 no X", 32'($isunknown({pll_rst, sys_rst_n, running, retry_cnt, loss_cnt})), 32'd0);
        end

        // No lock: 24-edge retry period and saturation at 255
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(23);
        check("t2 pll_rst low edge 22", 32'(pll_rst), 32'd0);
        check("t2 retry before timeout", 32'(retry_cnt), 32'd0);
        step(1);
        check("t2 pll_rst edge 23", 32'(pll_rst), 32'd1);
        check("t2 retry first", 32'(retry_cnt), 32'd1);
        step(24 * 253);
        check("t2 retry 254", 32'(retry_cnt), 32'd254);
        step(24);
        check("t2 retry 255", 32'(retry_cnt), 32'd255);
        step(24 * 45);
        check("t2 retry saturated", 32'(retry_cnt), 32'd255);
        check("t2 pll_rst period", 32'(pll_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
